// File: rtl/rr_multi_arbiter.sv
// ============================================================================
// Module  : rr_multi_arbiter
// Brief   : Multi-grant (up to AMOUNT_M) fixed/round-robin arbiter with a
//           single registered output stage and valid/ready on both sides.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_multi_arbiter #(
  parameter int WIDTH_N  = 10,
  parameter int AMOUNT_M = 2,
  parameter int IDX_W    = $clog2(WIDTH_N),
  parameter int CNT_W    = $clog2(AMOUNT_M + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [WIDTH_N-1:0]                 req_i,
  input  logic                               mode_rr_i,
  input  logic                               req_vld_i,
  output logic                               req_rdy_o,
  output logic [AMOUNT_M-1:0][WIDTH_N-1:0]   gnt_o,
  output logic [AMOUNT_M-1:0][IDX_W-1:0]     gnt_idx_o,
  output logic [CNT_W-1:0]                   gnt_num_o,
  output logic                               gnt_vld_o,
  input  logic                               gnt_rdy_i
);

  logic [AMOUNT_M-1:0][WIDTH_N-1:0] r_gnt;
  logic [AMOUNT_M-1:0][IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]                 r_num;
  logic                             r_vld;
  logic [IDX_W-1:0]                 r_ptr;

  logic [AMOUNT_M-1:0][WIDTH_N-1:0] w_gnt;
  logic [AMOUNT_M-1:0][IDX_W-1:0]   w_idx;
  logic [CNT_W-1:0]                 w_cnt;
  logic [IDX_W-1:0]                 w_last;
  logic [IDX_W-1:0]                 w_start;
  logic [IDX_W:0]                   w_pos;
  logic [IDX_W-1:0]                 w_ptr_nxt;
  logic                             w_accept;

  assign req_rdy_o = ~r_vld | gnt_rdy_i;
  assign w_accept  = req_vld_i & req_rdy_o;

  // Walk the request vector once in rotated order; w_pos carries one extra
  // bit so start+k never overflows before the explicit modulo subtraction.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_cnt   = '0;
    w_last  = '0;
    w_pos   = '0;
    w_start = mode_rr_i ? r_ptr : '0;
    for (int k = 0; k < WIDTH_N; k++) begin
      w_pos = {1'b0, w_start} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(WIDTH_N)) begin
        w_pos = w_pos - (IDX_W+1)'(WIDTH_N);
      end
      if (req_i[w_pos[IDX_W-1:0]] && (w_cnt < CNT_W'(AMOUNT_M))) begin
        w_gnt[w_cnt][w_pos[IDX_W-1:0]] = 1'b1;
        w_idx[w_cnt]                   = w_pos[IDX_W-1:0];
        w_last                         = w_pos[IDX_W-1:0];
        w_cnt                          = w_cnt + 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_last == IDX_W'(WIDTH_N - 1)) ? '0 : w_last + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt <= '0;
      r_idx <= '0;
      r_num <= '0;
      r_vld <= 1'b0;
      r_ptr <= '0;
    end else if (w_accept) begin
      r_gnt <= w_gnt;
      r_idx <= w_idx;
      r_num <= w_cnt;
      r_vld <= 1'b1;
      // Fixed-mode and empty requests leave the round-robin pointer alone.
      if (mode_rr_i && (w_cnt != '0)) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (req_rdy_o) begin
      r_vld <= 1'b0;
    end
  end

  assign gnt_o     = r_gnt;
  assign gnt_idx_o = r_idx;
  assign gnt_num_o = r_num;
  assign gnt_vld_o = r_vld;

`ifndef SYNTHESIS
  a_req_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (req_vld_i && !req_rdy_o) |=> (req_vld_i && $stable(req_i) && $stable(mode_rr_i)));

  a_out_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (gnt_vld_o && !gnt_rdy_i) |=> (gnt_vld_o && $stable(gnt_o) &&
                                   $stable(gnt_idx_o) && $stable(gnt_num_o)));

  for (genvar k = 0; k < AMOUNT_M; k++) begin : g_slot_chk
    a_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      w_accept |-> ($onehot0(w_gnt[k]) && ((w_gnt[k] & ~req_i) == '0)));
    for (genvar j = 0; j < k; j++) begin : g_pair_chk
      a_disjoint: assert property (@(posedge clk) disable iff (!reset_n)
        w_accept |-> ((w_gnt[j] & w_gnt[k]) == '0));
    end
  end
`endif

endmodule

`default_nettype wire
